// File: rtl/hash_msg_sequencer.sv
// Front-end for a 32-bit block hash core: packs a byte stream into padded 4-byte blocks,
// runs the core once per block with Merkle-Damgard chaining and hands out the final digest.
module hash_msg_sequencer #(
  parameter logic [31:0] IV0     = 32'h6A09E667,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        h_start,
  output logic [31:0] h_m,
  output logic [31:0] h_iv,
  input  logic [31:0] h_d,
  input  logic        h_done,
  output logic [31:0] digest,
  output logic        digest_valid,
  input  logic        digest_ready,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_ISSUE, S_WAIT, S_OUT} state_e;

  state_e          state_q, state_d;
  logic [31:0]     buf_q, buf_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            final_q, final_d;
  logic            pad_q, pad_d;
  logic [31:0]     h_m_q, h_m_d;
  logic [31:0]     h_iv_q, h_iv_d;
  logic [31:0]     digest_q, digest_d;
  logic            done_prev_q, done_prev_d;
  logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;
  logic [31:0]     blk_s;
  logic            done_edge_s;
  logic            timeout_s;

  // Byte 0 of a block occupies bits 31:24.
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  assign done_edge_s = h_done & ~done_prev_q;
  assign timeout_s   = (wait_cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    blk_s = put_byte(buf_q, cnt_q, s_data);
    if (s_last) begin
      case (cnt_q)
        2'd0:    blk_s[23:0] = 24'h800000;
        2'd1:    blk_s[15:0] = 16'h8000;
        2'd2:    blk_s[7:0]  = 8'h80;
        default: blk_s       = blk_s;
      endcase
    end else begin
      blk_s = blk_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      buf_q       <= 32'h0;
      cnt_q       <= 2'd0;
      final_q     <= 1'b0;
      pad_q       <= 1'b0;
      h_m_q       <= 32'h0;
      h_iv_q      <= IV0;
      digest_q    <= 32'h0;
      done_prev_q <= 1'b0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      final_q     <= final_d;
      pad_q       <= pad_d;
      h_m_q       <= h_m_d;
      h_iv_q      <= h_iv_d;
      digest_q    <= digest_d;
      done_prev_q <= done_prev_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (s_valid) state_d = S_COLLECT; else state_d = S_IDLE;
      S_COLLECT: if (s_valid && (s_last || cnt_q == 2'd3)) state_d = S_ISSUE;
                 else state_d = S_COLLECT;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT: begin
        if (done_edge_s) begin
          if (final_q)    state_d = S_OUT;
          else if (pad_q) state_d = S_ISSUE;
          else            state_d = S_COLLECT;
        end else if (timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_OUT:     if (digest_ready) state_d = S_IDLE; else state_d = S_OUT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: block assembly, chaining and the WAIT watchdog.
  always_comb begin
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    final_d     = final_q;
    pad_d       = pad_q;
    h_m_d       = h_m_q;
    h_iv_d      = h_iv_q;
    digest_d    = digest_q;
    done_prev_d = h_done;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    case (state_q)
      S_COLLECT: begin
        if (s_valid) begin
          buf_d = blk_s;
          cnt_d = cnt_q + 2'd1;
          if (s_last || cnt_q == 2'd3) begin
            h_m_d = blk_s;
            cnt_d = 2'd0;
            if (s_last && cnt_q == 2'd3) pad_d = 1'b1;
            else if (s_last)             final_d = 1'b1;
            else                         pad_d = pad_q;
          end else begin
            h_m_d = h_m_q;
          end
        end else begin
          buf_d = buf_q;
        end
      end
      S_ISSUE: begin
        cnt_d      = 2'd0;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + TW'(1);
        if (done_edge_s) begin
          if (final_q) begin
            digest_d = h_d;
          end else begin
            h_iv_d = h_d;
            if (pad_q) begin
              buf_d   = 32'h80000000;
              h_m_d   = 32'h80000000;
              pad_d   = 1'b0;
              final_d = 1'b1;
            end else begin
              pad_d = 1'b0;
            end
          end
        end else if (timeout_s) begin
          // Abandon the message: chaining restarts from IV0 for whatever comes next.
          err_d   = 1'b1;
          h_iv_d  = IV0;
          final_d = 1'b0;
          pad_d   = 1'b0;
          buf_d   = 32'h0;
          cnt_d   = 2'd0;
        end else begin
          err_d = err_q;
        end
      end
      S_OUT: begin
        if (digest_ready) begin
          h_iv_d  = IV0;
          final_d = 1'b0;
        end else begin
          final_d = final_q;
        end
      end
      default: begin
        err_d = err_q;
      end
    endcase
  end

  always_comb begin
    s_ready      = 1'b0;
    h_start      = 1'b0;
    digest_valid = 1'b0;
    case (state_q)
      S_COLLECT: s_ready      = 1'b1;
      S_ISSUE:   h_start      = 1'b1;
      S_OUT:     digest_valid = 1'b1;
      default:   s_ready      = 1'b0;
    endcase
  end

  assign h_m    = h_m_q;
  assign h_iv   = h_iv_q;
  assign digest = digest_q;
  assign err    = err_q;

endmodule

// File: tb/tb_hash_msg_sequencer.sv
// Bench for hash_msg_sequencer: a 27-cycle core model plus a message-level reference
// (pad to whole words, chain blocks from IV0) checked with immediate assertions.
module tb_hash_msg_sequencer;

  localparam logic [31:0] IV0 = 32'h6A09E667;
  localparam int TIMEOUT = 64;
  localparam int CORE_LAT = 27;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        h_start;
  logic [31:0] h_m, h_iv, digest;
  logic [31:0] h_d = 32'h0;
  logic        h_done = 1'b0;
  logic        digest_valid;
  logic        digest_ready = 1'b0;
  logic        err;

  int n_checks = 0;
  int n_err = 0;

  hash_msg_sequencer #(.IV0(IV0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .h_start(h_start), .h_m(h_m), .h_iv(h_iv), .h_d(h_d), .h_done(h_done),
    .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] core_f(input logic [31:0] m, input logic [31:0] iv);
    return (({iv[20:0], iv[31:21]} ^ m) + (m * 32'h9E3779B1)) ^ 32'h5BD1E995;
  endfunction

  // Core model: everything it sees is recorded for later comparison by the main sequence.
  logic [31:0] obs_m[$];
  logic [31:0] obs_iv[$];
  int          busy = 0;
  int          rdy_busy_cnt = 0;
  logic [31:0] pend_m = 32'h0, pend_iv = 32'h0;
  bit          core_dead = 1'b0;

  always @(negedge clk) begin
    if (busy != 0 && s_ready) rdy_busy_cnt <= rdy_busy_cnt + 1;
    if (h_start) begin
      obs_m.push_back(h_m);
      obs_iv.push_back(h_iv);
      pend_m  <= h_m;
      pend_iv <= h_iv;
      busy    <= CORE_LAT;
      h_done  <= 1'b0;
    end else if (busy > 1) begin
      busy <= busy - 1;
    end else if (busy == 1) begin
      busy <= 0;
      if (!core_dead) begin
        h_done <= 1'b1;
        h_d    <= core_f(pend_m, pend_iv);
      end
    end else begin
      h_done <= 1'b0;
    end
  end

  logic [7:0]  msg[$];
  logic [31:0] exp_m[$];
  logic [31:0] exp_iv[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: append 0x80, zero-fill to a whole word, chain every word from IV0.
  task automatic build_exp(output logic [31:0] dig);
    logic [7:0]  p[$];
    logic [31:0] iv, w;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 4 != 0) p.push_back(8'h00);
    exp_m.delete();
    exp_iv.delete();
    iv = IV0;
    for (int b = 0; b < p.size() / 4; b++) begin
      w = {p[4*b], p[4*b+1], p[4*b+2], p[4*b+3]};
      exp_m.push_back(w);
      exp_iv.push_back(iv);
      iv = core_f(w, iv);
    end
    dig = iv;
  endtask

  task automatic send_msg();
    int guard;
    for (int i = 0; i < msg.size(); i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      s_valid = 1'b1;
      s_data  = msg[i];
      s_last  = (i == msg.size() - 1);
      guard = 0;
      while (!s_ready && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      chk("accept_bound", 32'(guard >= 500), 32'd0);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic run_msg(input string tag, input int hold);
    logic [31:0] dig, held;
    int n0, rb0, guard;
    build_exp(dig);
    n0  = obs_m.size();
    rb0 = rdy_busy_cnt;
    send_msg();
    guard = 0;
    while (!digest_valid && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_digest_bound"}, 32'(guard >= 2000), 32'd0);
    chk({tag, "_digest"}, digest, dig);
    chk({tag, "_starts"}, 32'(obs_m.size() - n0), 32'(exp_m.size()));
    for (int b = 0; b < exp_m.size() && n0 + b < obs_m.size(); b++) begin
      chk({tag, "_m"}, obs_m[n0 + b], exp_m[b]);
      chk({tag, "_iv"}, obs_iv[n0 + b], exp_iv[b]);
    end
    chk({tag, "_sready_in_wait"}, 32'(rdy_busy_cnt - rb0), 32'd0);
    held = digest;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(digest_valid), 32'd1);
      chk({tag, "_hold_digest"}, digest, held);
      chk({tag, "_hold_sready"}, 32'(s_ready), 32'd0);
    end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(digest_valid), 32'd0);
    chk({tag, "_iv_restore"}, h_iv, IV0);
  endtask

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    chk("rst_sready", 32'(s_ready), 32'd0);
    chk("rst_hstart", 32'(h_start), 32'd0);
    chk("rst_dvalid", 32'(digest_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_hm", h_m, 32'h0);
    chk("rst_hiv", h_iv, IV0);
    chk("rst_digest", digest, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    msg = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_msg("t1", 1);
    chk("t1_pad_block", exp_m[1], 32'h80000000);
    msg = '{8'hAA};
    run_msg("t2", 0);
    chk("t2_block", exp_m[0], 32'hAA800000);
    msg = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_msg("t3", 2);
    msg = '{8'h11, 8'h22, 8'h33};
    run_msg("t4", 10);

    for (int r = 0; r < 6; r++) begin
      msg.delete();
      repeat ($urandom_range(1, 9)) msg.push_back(8'($urandom));
      run_msg("rnd", $urandom_range(0, 3));
    end

    // Reset in the middle of the second block's WAIT.
    msg = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
    send_msg();
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_sready", 32'(s_ready), 32'd0);
    chk("t5_hstart", 32'(h_start), 32'd0);
    chk("t5_dvalid", 32'(digest_valid), 32'd0);
    chk("t5_hm", h_m, 32'h0);
    chk("t5_hiv", h_iv, IV0);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = obs_m.size();
    repeat (40) @(negedge clk);
    chk("t5_late_dvalid", 32'(digest_valid), 32'd0);
    chk("t5_late_sready", 32'(s_ready), 32'd0);
    chk("t5_late_starts", 32'(obs_m.size() - n0), 32'd0);
    msg = '{8'h5A, 8'hA5};
    run_msg("t5_after", 0);

    // Dead core: the watchdog must fire exactly TIMEOUT cycles into WAIT.
    core_dead = 1'b1;
    msg = '{8'hDE, 8'hAD};
    send_msg();
    chk("t6_issue", 32'(h_start), 32'd1);
    repeat (TIMEOUT) @(negedge clk);
    chk("t6_err_early", 32'(err), 32'd0);
    @(negedge clk);
    chk("t6_err", 32'(err), 32'd1);
    chk("t6_sready", 32'(s_ready), 32'd0);
    chk("t6_dvalid", 32'(digest_valid), 32'd0);
    chk("t6_hiv", h_iv, IV0);
    core_dead = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_err_sticky", 32'(err), 32'd1);
    msg = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    run_msg("t6_after", 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
